// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM type, default NOP word and address helper for the instruction memory
package imem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_e;
   localparam logic [31:0] IMEM_NOP = 32'h0000_0013;
   function automatic logic [29:0] word_idx(input logic [31:0] addr);
      return 30'(addr >> 2);
   endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: 1R1W synchronous word RAM with registered, read-before-write read port
module imem_array #(
   parameter int DEPTH = 1024,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data
);
   logic [31:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (wr_en) mem[wr_addr] <= wr_data;
   always_ff @(posedge clk)
      if (rst) rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction store answering level fetch requests with a one-cycle strobe
module imem_responder
   import imem_pkg::*;
#(
   parameter int          DEPTH    = 1024,
   parameter int          LATENCY  = 2,
   parameter logic [31:0] NOP_WORD = IMEM_NOP
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic        read_i,
   output logic [31:0] data_o,
   output logic        valid_o,
   output logic        err_o,
   input  logic        wr_en_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1) > 1 ? $clog2(LATENCY + 1) : 1;
   imem_state_e state, next;
   logic [31:0] addr_q, rd_data;
   logic [CW-1:0] cnt;
   logic [29:0] rd_idx, wr_idx;
   logic err_q, redirect, in_range, rd_en, wr_ok;
   // LATENCY==1 goes straight to RESP, so the read index comes from addr_i only in IDLE
   assign rd_idx   = word_idx(state == IDLE ? addr_i : addr_q);
   assign wr_idx   = word_idx(wr_addr_i);
   assign in_range = (rd_idx >> AW) == '0;
   assign wr_ok    = wr_en_i && (wr_idx >> AW) == '0;
   assign redirect = state == WAIT && read_i && addr_i != addr_q;
   assign rd_en    = next == RESP && in_range;
   always_ff @(posedge clk)
      if (rst_i) state <= IDLE;
      else state <= next;
   always_comb
      next = state == IDLE ? (read_i ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
           : state == WAIT ? (!redirect && cnt == CW'(1) ? RESP : WAIT)
           : IDLE;
   always_comb begin
      valid_o = state == RESP;
      err_o   = valid_o && err_q;
      data_o  = err_q ? NOP_WORD : rd_data;
   end
   always_ff @(posedge clk)
      if (rst_i) begin
         addr_q <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
      end else begin
         if ((state == IDLE && read_i) || redirect) begin
            addr_q <= addr_i;
            cnt    <= CW'(LATENCY - 1);
         end else if (state == WAIT) cnt <= cnt - CW'(1);
         if (next == RESP) err_q <= !in_range;
      end
   imem_array #(.DEPTH(DEPTH)) u_array (
      .clk(clk),
      .rst(rst_i),
      .rd_en(rd_en),
      .rd_addr(rd_idx[AW-1:0]),
      .rd_data(rd_data),
      .wr_en(wr_ok),
      .wr_addr(wr_idx[AW-1:0]),
      .wr_data(wr_data_i)
   );
endmodule
